// File: rtl/dsi_packet_assembler.sv
// DSI packet assembler: builds short/long packets (header ECC, payload, CRC-16) as byte-packed 32-bit words.
// Optional feature macro: DSI_PKT_CRC_EN (defined = CRC-16 computed; undefined = checksum field sent as 16'h0000).
module dsi_packet_assembler #(
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_long,
  input  logic [1:0]  cmd_vc,
  input  logic [5:0]  cmd_dt,
  input  logic [15:0] cmd_wc,
  input  logic [31:0] pld_data,
  input  logic        pld_valid,
  output logic        pld_ready,
  output logic [31:0] iface_write_data,
  output logic [3:0]  iface_write_strb,
  output logic        iface_write_rqst,
  output logic        iface_last_word,
  input  logic        iface_data_rqst,
  output logic        busy
);

`ifdef DSI_PKT_CRC_EN
  localparam logic [15:0] CRC_MASK = '1;
`else
  localparam logic [15:0] CRC_MASK = '0;
`endif
  localparam logic [15:0] CRC_SEED = CRC_INIT & CRC_MASK;

  typedef enum logic [1:0] {IDLE, HDR, PLD, TAIL} state_t;

  state_t      state;
  logic        is_long;
  logic [15:0] bytes_left;
  logic [15:0] crc;
  logic        tail_out;
  logic        tail_one;

  logic [23:0] hdr;
  logic [5:0]  ecc;
  logic        xfer;
  logic        consume;
  logic        last_pld;
  logic [15:0] crc_next;

`ifdef DSI_PKT_CRC_EN
  logic [2:0] nbytes;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction
`endif

  always_comb begin
    hdr     = {cmd_wc, cmd_vc, cmd_dt};
    ecc[0]  = ^(hdr & 24'hF12CB7);
    ecc[1]  = ^(hdr & 24'hF2555B);
    ecc[2]  = ^(hdr & 24'h749A6D);
    ecc[3]  = ^(hdr & 24'hB8E38E);
    ecc[4]  = ^(hdr & 24'hDF03F0);
    ecc[5]  = ^(hdr & 24'hEFFC00);
    xfer      = iface_write_rqst && iface_data_rqst;
    pld_ready = (state == PLD) && (!iface_write_rqst || iface_data_rqst);
    consume   = pld_valid && pld_ready;
    last_pld  = (bytes_left <= 16'd4);
`ifdef DSI_PKT_CRC_EN
    nbytes   = last_pld ? bytes_left[2:0] : 3'd4;
    crc_next = crc;
    for (int unsigned i = 0; i < 4; i++)
      if (i < 32'(nbytes)) crc_next = crc_byte(crc_next, pld_data[8*i +: 8]);
`else
    crc_next = '0;
`endif
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE) || (cmd_valid && cmd_ready);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state            <= IDLE;
      is_long          <= 1'b0;
      bytes_left       <= '0;
      crc              <= '0;
      tail_out         <= 1'b0;
      tail_one         <= 1'b0;
      iface_write_data <= '0;
      iface_write_strb <= '0;
      iface_write_rqst <= 1'b0;
      iface_last_word  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          is_long          <= cmd_long;
          bytes_left       <= cmd_long ? cmd_wc : '0;
          crc              <= CRC_SEED;
          tail_out         <= 1'b0;
          iface_write_data <= {2'b00, ecc, hdr};
          iface_write_strb <= 4'hF;
          iface_write_rqst <= 1'b1;
          iface_last_word  <= !cmd_long;
          state            <= HDR;
        end
        HDR: if (xfer) begin
          if (!is_long) begin
            iface_write_rqst <= 1'b0;
            iface_last_word  <= 1'b0;
            state            <= IDLE;
          end else if (bytes_left == '0) begin
            iface_write_data <= {16'h0000, crc};
            iface_write_strb <= 4'h3;
            iface_last_word  <= 1'b1;
            tail_out         <= 1'b1;
            state            <= TAIL;
          end else begin
            iface_write_rqst <= 1'b0;
            state            <= PLD;
          end
        end
        PLD: begin
          if (consume) begin
            iface_write_rqst <= 1'b1;
            crc              <= crc_next;
            bytes_left       <= last_pld ? '0 : bytes_left - 16'd4;
            if (!last_pld) begin
              iface_write_data <= pld_data;
              iface_write_strb <= 4'hF;
              iface_last_word  <= 1'b0;
            end else begin
              // CRC bytes follow the last payload byte; whatever does not fit spills into TAIL
              state <= TAIL;
              case (bytes_left[2:0])
                3'd4: begin
                  iface_write_data <= pld_data;
                  iface_write_strb <= 4'hF;
                  iface_last_word  <= 1'b0;
                  tail_out         <= 1'b0;
                  tail_one         <= 1'b0;
                end
                3'd3: begin
                  iface_write_data <= {crc_next[7:0], pld_data[23:0]};
                  iface_write_strb <= 4'hF;
                  iface_last_word  <= 1'b0;
                  tail_out         <= 1'b0;
                  tail_one         <= 1'b1;
                end
                3'd2: begin
                  iface_write_data <= {crc_next, pld_data[15:0]};
                  iface_write_strb <= 4'hF;
                  iface_last_word  <= 1'b1;
                  tail_out         <= 1'b1;
                end
                default: begin
                  iface_write_data <= {8'h00, crc_next, pld_data[7:0]};
                  iface_write_strb <= 4'h7;
                  iface_last_word  <= 1'b1;
                  tail_out         <= 1'b1;
                end
              endcase
            end
          end else if (xfer) begin
            iface_write_rqst <= 1'b0;
          end
        end
        TAIL: begin
          if (tail_out) begin
            if (xfer) begin
              iface_write_rqst <= 1'b0;
              iface_last_word  <= 1'b0;
              tail_out         <= 1'b0;
              state            <= IDLE;
            end
          end else if (!iface_write_rqst || iface_data_rqst) begin
            iface_write_data <= tail_one ? {24'h000000, crc[15:8]} : {16'h0000, crc};
            iface_write_strb <= tail_one ? 4'h1 : 4'h3;
            iface_write_rqst <= 1'b1;
            iface_last_word  <= 1'b1;
            tail_out         <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Self-checking bench for dsi_packet_assembler: vector table, randomized packets vs. byte-stream model, reset corner.
module tb_dsi_packet_assembler;
  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_long;
  logic [1:0]  cmd_vc;
  logic [5:0]  cmd_dt;
  logic [15:0] cmd_wc;
  logic [31:0] pld_data;
  logic        pld_valid, pld_ready;
  logic [31:0] iface_write_data;
  logic [3:0]  iface_write_strb;
  logic        iface_write_rqst, iface_last_word, iface_data_rqst, busy;

  always #5 clk_sys = ~clk_sys;

  dsi_packet_assembler #(.CRC_INIT(16'hFFFF)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_long(cmd_long),
    .cmd_vc(cmd_vc), .cmd_dt(cmd_dt), .cmd_wc(cmd_wc),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
    .iface_write_data(iface_write_data), .iface_write_strb(iface_write_strb),
    .iface_write_rqst(iface_write_rqst), .iface_last_word(iface_last_word),
    .iface_data_rqst(iface_data_rqst), .busy(busy)
  );

`ifdef DSI_PKT_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  // Hamming syndrome contributed by each header bit (P5..P0)
  localparam logic [5:0] SYN [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          res_words, res_last_strb, res_cycles;
  logic [31:0] res_last_data;

  typedef struct {
    bit          lng;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    int          words;
    int          lstrb;
    int          cycles;
    bit          chk_ld;
    logic [31:0] ldata;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ecc_ref(input logic [23:0] d);
    logic [5:0] e;
    e = '0;
    for (int i = 0; i < 24; i++) if (d[i]) e ^= SYN[i];
    return {2'b00, e};
  endfunction

  function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ b[k];
      r  = r >> 1;
      if (fb) r ^= 16'h8408;
    end
    return r;
  endfunction

  function automatic int strb_of(input int n);
    case (n % 4)
      1:       return 1;
      2:       return 3;
      3:       return 7;
      default: return 15;
    endcase
  endfunction

  task automatic run_packet(input bit lng, input logic [1:0] vc, input logic [5:0] dt,
                            input logic [15:0] wc, input bit rnd, input int abort_at,
                            input string tag);
    logic [31:0] pw[$];
    logic [15:0] c;
    logic [7:0]  bt;
    logic [31:0] held_d;
    bit   held, accepted, done, pr_after;
    int   cyc, pi, acc_cyc, first_rq, hdr_x, early, unstable, badfmt, busy_cnt, gap, mism, nw;
    pw.delete(); exp_q.delete(); got_q.delete();
    exp_q.push_back({vc, dt});
    exp_q.push_back(wc[7:0]);
    exp_q.push_back(wc[15:8]);
    exp_q.push_back(ecc_ref({wc, vc, dt}));
    if (lng) begin
      nw = (int'(wc) + 3) / 4;
      for (int i = 0; i < nw; i++) pw.push_back($urandom);
      c = CRC_ON ? 16'hFFFF : 16'h0000;
      for (int k = 0; k < int'(wc); k++) begin
        bt = pw[k/4][8*(k%4) +: 8];
        exp_q.push_back(bt);
        if (CRC_ON) c = crc_bits(c, bt);
      end
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
    end
    cmd_long = lng; cmd_vc = vc; cmd_dt = dt; cmd_wc = wc;
    held = 0; accepted = 0; done = 0; pr_after = 0; held_d = '0;
    cyc = 0; pi = 0; acc_cyc = -1; first_rq = -1; hdr_x = -1;
    early = 0; unstable = 0; badfmt = 0; busy_cnt = 0; gap = 0;
    res_words = 0; res_last_strb = 0; res_last_data = '0;
    while (!done && cyc < 5000) begin
      if (cyc == abort_at) return;
      cmd_valid = !accepted;
      if (gap > 0) begin
        iface_data_rqst = 1'b0;
        gap--;
      end else begin
        iface_data_rqst = 1'b1;
        if (rnd && $urandom_range(0, 2) == 0) gap = $urandom_range(1, 6);
      end
      if (accepted && pi < pw.size()) begin
        pld_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        pld_data  = pw[pi];
      end else begin
        pld_valid = 1'b0;
        pld_data  = $urandom;
      end
      #1;
      if (busy) busy_cnt++;
      if (!accepted && cmd_valid && cmd_ready) begin
        accepted = 1;
        acc_cyc  = cyc;
      end
      if (iface_write_rqst && first_rq < 0) first_rq = cyc;
      if (pld_ready && (hdr_x < 0 || cyc == hdr_x)) early++;
      if (hdr_x >= 0 && cyc == hdr_x + 1) pr_after = pld_ready;
      if (held && (!iface_write_rqst || iface_write_data !== held_d)) unstable++;
      if (pld_valid && pld_ready) pi++;
      if (iface_write_rqst && iface_data_rqst) begin
        res_words++;
        if (res_words == 1) hdr_x = cyc;
        if (!(iface_write_strb inside {4'h1, 4'h3, 4'h7, 4'hF})) badfmt++;
        for (int b = 0; b < 4; b++) begin
          if (iface_write_strb[b]) got_q.push_back(iface_write_data[8*b +: 8]);
          else if (iface_write_data[8*b +: 8] != 8'h00) badfmt++;
        end
        res_last_strb = int'(iface_write_strb);
        res_last_data = iface_write_data;
        if (iface_last_word) done = 1;
        held = 0;
      end else begin
        held   = iface_write_rqst;
        held_d = iface_write_data;
      end
      @(posedge clk_sys); #1;
      cyc++;
    end
    res_cycles = cyc;
    check({tag, "_timeout"}, 32'(done), 32'd1);
    mism = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_stream_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    check({tag, "_stream_bytes_bad"}, 32'(mism), 32'd0);
    check({tag, "_hdr_latency"}, 32'(first_rq), 32'(acc_cyc + 1));
    check({tag, "_unstable"}, 32'(unstable), 32'd0);
    check({tag, "_badfmt"}, 32'(badfmt), 32'd0);
    check({tag, "_pld_ready_early"}, 32'(early), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(res_cycles));
    if (lng && wc != 16'd0) check({tag, "_pld_ready_after_hdr"}, 32'(pr_after), 32'd1);
    cmd_valid = 1'b0; pld_valid = 1'b0; iface_data_rqst = 1'b1;
    #1;
    check({tag, "_idle_gap_rqst"}, 32'(iface_write_rqst), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    @(posedge clk_sys); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc_r;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_long = 1'b0; cmd_vc = '0; cmd_dt = '0; cmd_wc = '0;
    pld_data = '0; pld_valid = 1'b0; iface_data_rqst = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_pld_ready", 32'(pld_ready), 32'd0);
    check("rst_data", iface_write_data, 32'd0);
    check("rst_strb", 32'(iface_write_strb), 32'd0);
    check("rst_rqst", 32'(iface_write_rqst), 32'd0);
    check("rst_last", 32'(iface_last_word), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk_sys); #1;

    tbl[0] = '{0, 2'd0, 6'h00, 16'h0000, 1, 15, 2, 1, 32'h0000_0000};
    tbl[1] = '{1, 2'd1, 6'h29, 16'd0,    2, 3,  3, 1, {16'h0000, CRC_ON ? 16'hFFFF : 16'h0000}};
    tbl[2] = '{1, 2'd0, 6'h39, 16'd4,    3, 3,  5, 0, 32'h0};
    tbl[3] = '{1, 2'd2, 6'h29, 16'd5,    3, 7,  5, 0, 32'h0};
    tbl[4] = '{1, 2'd3, 6'h3E, 16'd6,    3, 15, 5, 0, 32'h0};
    tbl[5] = '{1, 2'd1, 6'h19, 16'd7,    4, 1,  6, 0, 32'h0};
    tbl[6] = '{0, 2'd3, 6'h15, 16'hA5C3, 1, 15, 2, 0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      run_packet(tbl[i].lng, tbl[i].vc, tbl[i].dt, tbl[i].wc, 1'b0, -1, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_words", i), 32'(res_words), 32'(tbl[i].words));
      check($sformatf("vec%0d_last_strb", i), 32'(res_last_strb), 32'(tbl[i].lstrb));
      check($sformatf("vec%0d_cycles", i), 32'(res_cycles), 32'(tbl[i].cycles));
      if (tbl[i].chk_ld) check($sformatf("vec%0d_last_data", i), res_last_data, tbl[i].ldata);
    end

    for (int p = 0; p < 14; p++) begin
      wc_r = $urandom_range(4, 256);
      run_packet(1'b1, 2'($urandom), 6'($urandom), 16'(wc_r), 1'b1, -1, $sformatf("rnd%0d", p));
      check($sformatf("rnd%0d_words", p), 32'(res_words), 32'(1 + (wc_r + 5) / 4));
      check($sformatf("rnd%0d_last_strb", p), 32'(res_last_strb), 32'(strb_of(wc_r + 2)));
    end

    run_packet(1'b1, 2'd2, 6'h3E, 16'd64, 1'b0, 6, "abort");
    cmd_valid = 1'b0; pld_valid = 1'b1; iface_data_rqst = 1'b0;
    rst_n = 1'b0;
    @(posedge clk_sys); #1;
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_pld_ready", 32'(pld_ready), 32'd0);
    check("midrst_data", iface_write_data, 32'd0);
    check("midrst_strb", 32'(iface_write_strb), 32'd0);
    check("midrst_rqst", 32'(iface_write_rqst), 32'd0);
    check("midrst_last", 32'(iface_last_word), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; pld_valid = 1'b0;
    @(posedge clk_sys); #1;
    run_packet(1'b0, 2'd1, 6'h05, 16'h1234, 1'b0, -1, "post_rst");
    check("post_rst_words", 32'(res_words), 32'd1);
    check("post_rst_last_data", res_last_data, {ecc_ref(24'h123445), 24'h123445});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
